// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder.
package spi_slave_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST  = BIT_CNT_W'(BYTE_W - 1);
    localparam logic [BYTE_W-1:0]    IDLE_FILL_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_slave_iface_sync_edge.sv
// Multi-flop synchronizer with an extra history flop producing single-cycle
// rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall     = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_iface.sv
// SPI mode-0 responder, MSB first, 8-bit frames, oversampled on CLK.
// Define SPI_SLAVE_ECHO_EN to transmit the last received byte instead of IDLE_FILL.
module spi_slave_iface
    import spi_slave_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_FILL   = IDLE_FILL_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SPI_CLK,
    input  logic              SPI_CS_N,
    input  logic              SPI_DATA_IN,
    output logic              SPI_DATA_OUT,
    output logic              SPI_DATA_OUT_EN,
    input  logic [BYTE_W-1:0] DIN,
    input  logic              WE_IN,
    output logic              TX_RDY,
    output logic [BYTE_W-1:0] DOUT,
    output logic              WE_OUT,
    output logic              BUSY
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic din_sync, din_rise_unused, din_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (SPI_CLK),
        .sync_out (sclk_sync),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (SPI_CS_N),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (SPI_DATA_IN),
        .sync_out (din_sync),
        .rise     (din_rise_unused),
        .fall     (din_fall_unused)
    );

    state_t               state, state_nxt;
    logic                 load_tx, shift_tx, sample_rx;
    logic [BYTE_W-1:0]    tx_shift, rx_shift, rx_next, hold_reg, dout_q, fill_byte;
    logic                 hold_full, we_out_q;
    logic [BIT_CNT_W-1:0] bit_cnt;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // cs_rise takes priority, so a coincident sclk_rise samples nothing.
    always_comb begin
        state_nxt = state;
        load_tx   = 1'b0;
        shift_tx  = 1'b0;
        sample_rx = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_nxt = LOAD;
            end
            LOAD: begin
                load_tx   = 1'b1;
                state_nxt = cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else begin
                    sample_rx = sclk_rise;
                    if (sclk_fall) begin
                        load_tx  = (bit_cnt == '0);
                        shift_tx = (bit_cnt != '0);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_SLAVE_ECHO_EN
    assign fill_byte = dout_q;
`else
    assign fill_byte = IDLE_FILL;
`endif

    assign rx_next = {rx_shift[BYTE_W-2:0], din_sync};

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            dout_q    <= '0;
            we_out_q  <= 1'b0;
        end else begin
            we_out_q <= 1'b0;

            if (load_tx)       tx_shift <= hold_full ? hold_reg : fill_byte;
            else if (shift_tx) tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};

            // A write landing on an empty-register reload is kept for the next byte.
            if (load_tx && hold_full) begin
                hold_full <= 1'b0;
            end else if (WE_IN && !hold_full) begin
                hold_reg  <= DIN;
                hold_full <= 1'b1;
            end

            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (sample_rx) begin
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                rx_shift <= rx_next;
                if (bit_cnt == BIT_CNT_LAST) begin
                    dout_q   <= rx_next;
                    we_out_q <= 1'b1;
                end
            end
        end
    end

    assign SPI_DATA_OUT    = tx_shift[BYTE_W-1];
    assign SPI_DATA_OUT_EN = ~cs_sync;
    assign TX_RDY          = ~hold_full;
    assign DOUT            = dout_q;
    assign WE_OUT          = we_out_q;
    assign BUSY            = (state != IDLE);

    logic sclk_level_unused;
    assign sclk_level_unused = sclk_sync;

endmodule

// File: tb/tb_spi_slave_iface.sv
// Directed bench for spi_slave_iface: bit-banged SPI master plus a DOUT scoreboard.
module tb_spi_slave_iface;

    localparam int H = 3;  // SPI_CLK half period in CLK cycles

    logic       CLK = 1'b0;
    logic       RST, SPI_CLK, SPI_CS_N, SPI_DATA_IN;
    logic       SPI_DATA_OUT, SPI_DATA_OUT_EN;
    logic [7:0] DIN, DOUT;
    logic       WE_IN, TX_RDY, WE_OUT, BUSY;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_dout;
    logic [7:0] miso_v;
    int         k;

    spi_slave_iface dut (
        .CLK             (CLK),
        .RST             (RST),
        .SPI_CLK         (SPI_CLK),
        .SPI_CS_N        (SPI_CS_N),
        .SPI_DATA_IN     (SPI_DATA_IN),
        .SPI_DATA_OUT    (SPI_DATA_OUT),
        .SPI_DATA_OUT_EN (SPI_DATA_OUT_EN),
        .DIN             (DIN),
        .WE_IN           (WE_IN),
        .TX_RDY          (TX_RDY),
        .DOUT            (DOUT),
        .WE_OUT          (WE_OUT),
        .BUSY            (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic write_tx(input logic [7:0] d);
        DIN   = d;
        WE_IN = 1'b1;
        cyc(1);
        WE_IN = 1'b0;
    endtask

    task automatic cs_low();
        SPI_CS_N = 1'b0;
        cyc(6);
    endtask

    task automatic cs_high();
        cyc(H);
        SPI_CS_N = 1'b1;
        cyc(6);
    endtask

    // Mode 0 master: MISO is captured just before each rising SPI_CLK edge.
    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            SPI_DATA_IN = mosi[7-i];
            cyc(H);
            got[7-i] = SPI_DATA_OUT;
            SPI_CLK = 1'b1;
            cyc(H);
            SPI_CLK = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] mosi, input logic [7:0] exp_miso, input string tag);
        logic [7:0] got;
        exp_q.push_back(mosi);
        last_dout = mosi;
        spi_bits(mosi, 8, got);
        check(tag, got, exp_miso);
    endtask

    // Scoreboard: every WE_OUT pulse consumes one expected byte.
    always @(negedge CLK) begin
        if (!RST && WE_OUT === 1'b1) begin
            if (exp_q.size() == 0) check("we_out_spurious", WE_OUT, 32'd0);
            else                   check("dout", DOUT, exp_q.pop_front());
        end
    end

    initial begin
        RST         = 1'b1;
        SPI_CLK     = 1'b0;
        SPI_CS_N    = 1'b1;
        SPI_DATA_IN = 1'b0;
        DIN         = '0;
        WE_IN       = 1'b0;
        last_dout   = '0;
        cyc(3);
        check("rst_dout",   DOUT,            32'h00);
        check("rst_we_out", WE_OUT,          32'd0);
        check("rst_tx_rdy", TX_RDY,          32'd1);
        check("rst_sdo",    SPI_DATA_OUT,    32'd0);
        check("rst_sdo_en", SPI_DATA_OUT_EN, 32'd0);
        check("rst_busy",   BUSY,            32'd0);
        RST = 1'b0;
        cyc(3);

        // Empty holding register: master receives the fill byte.
        cs_low();
        check("t1_busy",   BUSY,            32'd1);
        check("t1_sdo_en", SPI_DATA_OUT_EN, 32'd1);
        xfer(8'hA5, 8'hFF, "t1_miso");
        cs_high();
        check("t1_sdo_en_off", SPI_DATA_OUT_EN, 32'd0);
        check("t1_busy_off",   BUSY,            32'd0);

        // Preloaded byte; TX_RDY returns one cycle after LOAD.
        write_tx(8'h3C);
        check("t2_tx_rdy_full", TX_RDY, 32'd0);
        SPI_CS_N = 1'b0;
        k = 0;
        while (BUSY !== 1'b1 && k < 10) begin
            cyc(1);
            k++;
        end
        check("t2_busy_load",    BUSY,   32'd1);
        check("t2_tx_rdy_load",  TX_RDY, 32'd0);
        cyc(1);
        check("t2_tx_rdy_after", TX_RDY, 32'd1);
        cyc(4);
        xfer(8'h00, 8'h3C, "t2_miso");
        cs_high();

        // Three-byte burst with refills between bytes.
        write_tx(8'h11);
        cs_low();
        check("t3_tx_rdy", TX_RDY, 32'd1);
        write_tx(8'h22);
        xfer(8'h01, 8'h11, "t3_miso0");
        xfer(8'h02, 8'h22, "t3_miso1");
        xfer(8'h03, 8'hFF, "t3_miso2");
        cs_high();

        // Abort after five bits: nothing delivered, DOUT holds.
        cs_low();
        spi_bits(8'hF0, 5, miso_v);
        cyc(H);
        SPI_CS_N = 1'b1;
        cyc(4);
        check("t4_busy_abort", BUSY, 32'd0);
        check("t4_dout_hold",  DOUT, {24'd0, last_dout});
        cyc(4);

        // Second write while full is dropped; next frame realigned to bit 0.
        write_tx(8'h55);
        check("t5_tx_rdy_full", TX_RDY, 32'd0);
        write_tx(8'h66);
        cs_low();
        xfer(8'h96, 8'h55, "t5_miso");
        cs_high();
        check("t5_tx_rdy_empty", TX_RDY, 32'd1);
        cs_low();
        xfer(8'h7E, 8'hFF, "t5_miso_no66");
        cs_high();

`ifdef SPI_SLAVE_ECHO_EN
        RST = 1'b1;
        cyc(2);
        RST = 1'b0;
        cyc(3);
        cs_low();
        xfer(8'hC3, 8'h00, "echo_miso0");
        xfer(8'h00, 8'hC3, "echo_miso1");
        cs_high();
`endif

        cyc(10);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
